// File: rtl/p2s_frame_tx.sv
// p2s_frame_tx
//   Parallel-to-serial frame transmitter. Accepts a 4-bit code on a valid/ready
//   handshake and sends it on a two-wire scl/sda pair:
//   START, 4 data bits MSB first, one trailing pulse with sda=0, then STOP.
//   The trailing pulse lets the downstream receiver's bit FSM reach its end
//   state before the next START.
//
//   Frame timing is counted in quarter periods of scl (QTR clocks each):
//     START 2 quarters, BIT 5 slots x 4 quarters, STOP 4 quarters = 26 quarters.
//
// Ports
//   clk    in   system clock, posedge
//   rst_n  in   synchronous reset, active low
//   data   in   [3:0] code, sampled on acceptance only
//   valid  in   request
//   ready  out  idle, a request is accepted this cycle
//   busy   out  frame in progress
//   done   out  one-clock pulse on the last cycle of STOP
//   scl    out  serial clock, idles high
//   sda    out  serial data, idles high
module p2s_frame_tx #(
  parameter int QTR = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       scl,
  output logic       sda
);

  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);
  localparam logic [QW-1:0] QPRE  = QW'(QTR - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

  state_t          state_q;
  logic [1:0]      q_q;       // quarter index within the current phase
  logic [QW-1:0]   qcnt_q;    // clocks within the current quarter
  logic [2:0]      bitcnt_q;  // slot 0..4
  logic [3:0]      shreg_q;
  logic            scl_q, sda_q, ready_q, busy_q, done_q;
  logic            qwrap_d;

  assign qwrap_d = (qcnt_q == QLAST);

  // Levels are applied on the edge that enters a quarter, so each assignment
  // below sets the levels of the quarter that follows the wrapping one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      q_q      <= 2'd0;
      qcnt_q   <= '0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 4'd0;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          if (valid && ready_q) begin
            shreg_q  <= data;
            state_q  <= S_START;
            q_q      <= 2'd0;
            qcnt_q   <= '0;
            bitcnt_q <= 3'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        default: begin
          if (qwrap_d) begin
            qcnt_q <= '0;
            q_q    <= q_q + 2'd1;
          end else begin
            qcnt_q <= qcnt_q + 1'b1;
          end

          // Raise done one clock ahead so it lands on the final STOP clock.
          if (state_q == S_STOP && q_q == 2'd3 && qcnt_q == QPRE)
            done_q <= 1'b1;

          if (qwrap_d) begin
            case (state_q)
              S_START: begin
                if (q_q == 2'd0) begin
                  sda_q <= 1'b0;          // start condition, scl high
                end else begin
                  state_q <= S_BIT;
                  q_q     <= 2'd0;
                  scl_q   <= 1'b0;
                end
              end
              S_BIT: begin
                case (q_q)
                  2'd0: begin
                    // Shifting MSB-first leaves zeros behind, so slot 4 sends 0.
                    sda_q   <= shreg_q[3];
                    shreg_q <= {shreg_q[2:0], 1'b0};
                  end
                  2'd1: scl_q <= 1'b1;
                  2'd2: ;
                  default: begin
                    scl_q <= 1'b0;
                    if (bitcnt_q == 3'd4) state_q  <= S_STOP;
                    else                  bitcnt_q <= bitcnt_q + 3'd1;
                  end
                endcase
              end
              S_STOP: begin
                case (q_q)
                  2'd0: sda_q <= 1'b0;
                  2'd1: scl_q <= 1'b1;
                  2'd2: sda_q <= 1'b1;    // stop condition, scl high
                  default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                  end
                endcase
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign scl   = scl_q;
  assign sda   = sda_q;

endmodule

// File: tb/tb_p2s_frame_tx.sv
module tb_p2s_frame_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] data4 = 4'd0, data2 = 4'd0, data7 = 4'd0;
  logic valid4 = 1'b0, valid2 = 1'b0, valid7 = 1'b0;
  logic ready4, busy4, done4, scl4, sda4;
  logic ready2, busy2, done2, scl2, sda2;
  logic ready7, busy7, done7, scl7, sda7;

  p2s_frame_tx #(.QTR(4)) u4 (.clk(clk), .rst_n(rst_n), .data(data4), .valid(valid4),
    .ready(ready4), .busy(busy4), .done(done4), .scl(scl4), .sda(sda4));
  p2s_frame_tx #(.QTR(2)) u2 (.clk(clk), .rst_n(rst_n), .data(data2), .valid(valid2),
    .ready(ready2), .busy(busy2), .done(done2), .scl(scl2), .sda(sda2));
  p2s_frame_tx #(.QTR(7)) u7 (.clk(clk), .rst_n(rst_n), .data(data7), .valid(valid7),
    .ready(ready7), .busy(busy7), .done(done7), .scl(scl7), .sda(sda7));

  int errors = 0;
  int checks = 0;

  // Bus-rule monitor on the QTR=4 instance, sampled on the falling edge.
  int   mon_viol = 0, mon_events = 0, m_rises = 0;
  logic m_ps = 1'b1, m_pd = 1'b1, m_pr = 1'b0;
  always @(negedge clk) begin
    if (rst_n && m_pr) begin
      if (sda4 !== m_pd) begin
        mon_events++;
        if (!((scl4 === m_ps) &&
              (!scl4 || (!sda4 && m_rises == 0) || (sda4 && m_rises == 6))))
          mon_viol++;
        if (scl4 && sda4) m_rises = 0;
      end
      if (scl4 && !m_ps) m_rises++;
    end else begin
      m_rises = 0;
    end
    m_ps = scl4; m_pd = sda4; m_pr = rst_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Starts in cycle 1 of a frame and follows it to the done cycle.
  // pulse_at: cycle at which a one-clock valid with data 4'b0011 is injected.
  task automatic collect4(input int pulse_at, output int len, output logic [4:0] bits,
                          output int rises, output bit st_ok, output bit sp_ok);
    logic ps, pd;
    int cnt;
    len = 0; bits = 5'd0; rises = 0; st_ok = 0; sp_ok = 0;
    ps = 1'b1; pd = 1'b1; cnt = 1;
    while (cnt <= 1000 && len == 0) begin
      if (cnt == pulse_at) begin valid4 = 1'b1; data4 = 4'b0011; end
      else if (cnt == pulse_at + 1) valid4 = 1'b0;
      if (scl4 && !ps) begin
        rises++;
        if (rises <= 5) bits = {bits[3:0], sda4};
      end
      if (ps && scl4 && pd && !sda4 && rises == 0) st_ok = 1;
      if (ps && scl4 && !pd && sda4 && rises == 6) sp_ok = 1;
      if (done4) len = cnt;
      ps = scl4; pd = sda4;
      if (len == 0) begin step(1); cnt++; end
    end
  endtask

  task automatic send4(input logic [3:0] code);
    data4 = code; valid4 = 1'b1;
    step(1);
    valid4 = 1'b0;
  endtask

  initial begin
    int len, rises, dcnt, l2, l7;
    logic [4:0] bits;
    bit st_ok, sp_ok;

    // 1: reset with valid asserted
    valid4 = 1'b1; data4 = 4'hF;
    step(3);
    chk("rst_scl", scl4, 1); chk("rst_sda", sda4, 1); chk("rst_ready", ready4, 1);
    chk("rst_busy", busy4, 0); chk("rst_done", done4, 0);
    valid4 = 1'b0; rst_n = 1'b1;
    step(2);
    chk("post_rst_ready", ready4, 1); chk("post_rst_busy", busy4, 0);

    // 2: single frame 1010
    send4(4'b1010);
    chk("t2_ready0", ready4, 0); chk("t2_busy1", busy4, 1);
    chk("t2_q0_scl", scl4, 1); chk("t2_q0_sda", sda4, 1);
    collect4(-10, len, bits, rises, st_ok, sp_ok);
    chk("t2_len", len, 104); chk("t2_bits", bits, 5'b10100); chk("t2_rises", rises, 6);
    chk("t2_start", st_ok, 1); chk("t2_stop", sp_ok, 1);
    step(1);
    chk("t2_done_fall", done4, 0); chk("t2_idle_ready", ready4, 1); chk("t2_idle_busy", busy4, 0);

    // 3: back-to-back 0000 then 1111 with valid held
    data4 = 4'b0000; valid4 = 1'b1;
    step(1);
    data4 = 4'b1111;
    chk("t3a_busy", busy4, 1);
    collect4(-10, len, bits, rises, st_ok, sp_ok);
    chk("t3a_len", len, 104); chk("t3a_bits", bits, 5'b00000);
    chk("t3a_ready_at_done", ready4, 0);
    step(1);
    chk("t3_gap_ready", ready4, 1); chk("t3_gap_done", done4, 0);
    step(1);
    valid4 = 1'b0;
    chk("t3b_ready0", ready4, 0); chk("t3b_busy", busy4, 1);
    chk("t3b_q0_scl", scl4, 1); chk("t3b_q0_sda", sda4, 1);
    collect4(-10, len, bits, rises, st_ok, sp_ok);
    chk("t3b_len", len, 104); chk("t3b_bits", bits, 5'b11110);
    chk("t3b_start", st_ok, 1); chk("t3b_stop", sp_ok, 1);
    step(6);
    chk("t3_idle_ready", ready4, 1); chk("t3_idle_busy", busy4, 0);

    // 4: valid pulse mid-frame is ignored
    send4(4'b1001);
    collect4(30, len, bits, rises, st_ok, sp_ok);
    chk("t4_len", len, 104); chk("t4_bits", bits, 5'b10010);
    step(20);
    chk("t4_no_extra_busy", busy4, 0); chk("t4_no_extra_ready", ready4, 1);
    chk("t4_idle_scl", scl4, 1); chk("t4_idle_sda", sda4, 1);

    // 5: reset during BIT slot 2, then a clean frame
    send4(4'b0110);
    step(44);
    chk("t5_busy_before", busy4, 1); chk("t5_scl_low_slot2", scl4, 0);
    rst_n = 1'b0;
    step(1);
    chk("t5_abort_scl", scl4, 1); chk("t5_abort_sda", sda4, 1);
    chk("t5_abort_busy", busy4, 0); chk("t5_abort_ready", ready4, 1);
    chk("t5_abort_done", done4, 0);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 120; i++) begin
      if (done4 || busy4) dcnt++;
      step(1);
    end
    chk("t5_no_done", dcnt, 0);
    send4(4'b0101);
    collect4(-10, len, bits, rises, st_ok, sp_ok);
    chk("t5_len", len, 104); chk("t5_bits", bits, 5'b01010); chk("t5_start", st_ok, 1);

    // 6: frame length for QTR=2 and QTR=7
    data2 = 4'b1011; data7 = 4'b0110; valid2 = 1'b1; valid7 = 1'b1;
    step(1);
    valid2 = 1'b0; valid7 = 1'b0;
    l2 = 0; l7 = 0;
    for (int c = 1; c <= 400 && (l2 == 0 || l7 == 0); c++) begin
      if (done2 && l2 == 0) l2 = c;
      if (done7 && l7 == 0) l7 = c;
      step(1);
    end
    chk("t6_len_q2", l2, 52); chk("t6_len_q7", l7, 182);

    step(2);
    chk("mon_sda_rule", mon_viol, 0);
    chk("mon_saw_events", (mon_events > 0) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
